trigger_sequencer: RTL and testbench
====================================

Name: trigger_sequencer

Overview:
Downstream consumer of the UART command decoder. It accepts a one-cycle pattern strobe plus a 2-bit rate code and emits a burst of fixed-width spectrometer trigger pulses at the selected repetition period. It also drives the board's six active-low status LEDs and reports burst completion.

Parameters:
CLOCK_FREQ, 27000000, sys_clk frequency in Hz (documentation and elaboration checks only)
PERIOD_0, 2700000, pulse period in cycles for rate code 0 (10 Hz)
PERIOD_1, 270000, pulse period in cycles for rate code 1 (100 Hz)
PERIOD_2, 27000, pulse period in cycles for rate code 2 (1 kHz)
PERIOD_3, 2700, pulse period in cycles for rate code 3 (10 kHz)
PULSE_WIDTH_CYC, 270, trigger high time in cycles (10 us)
ARM_CYC, 27, holdoff in cycles from strobe to first pulse; must be >= 1
BURST_LEN, 8, pulses per burst; range 1..255

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
new_pattern_in  in  1  single-cycle start strobe
pulse_rate  in  2  rate code; sampled only when new_pattern_in=1
trig_out  out  1  registered trigger output to the spectrometer
trig_active  out  1  high from the cycle after the strobe until the burst ends
burst_done  out  1  single-cycle completion strobe
pulse_count  out  8  pulses issued in the current burst
led  out  6  active-low status LEDs

Behaviour:
- Reset: trig_out=0, trig_active=0, burst_done=0, pulse_count=0, led=6'b111111, rate latch=0, state IDLE. All counters are cleared.
- States:
  - IDLE: outputs are quiet.
  - ARM: holdoff counter runs for ARM_CYC cycles.
  - HIGH: trig_out=1 for PULSE_WIDTH_CYC cycles.
  - LOW: trig_out=0 for PERIOD_x - PULSE_WIDTH_CYC cycles.
  - DONE: one cycle; burst_done=1. Next state is IDLE.
- Timing, with the strobe at cycle N:
  - State is ARM at N+1; trig_active=1 from N+1.
  - First trig_out rise is at N+1+ARM_CYC.
  - Successive rises are exactly PERIOD_x cycles apart.
  - Each rise increments pulse_count by 1, visible in the same cycle as the rise.
- Burst end: after the fall of pulse number BURST_LEN, go LOW -> DONE instead of HIGH. The LOW interval still completes in full, so DONE occurs PERIOD_x after the last rise. In the DONE cycle trig_active=0.
- pulse_count holds its final value in IDLE. It clears on the next strobe.
- Retrigger: new_pattern_in in any state (ARM/HIGH/LOW/DONE) does all of the following:
  - Latches the new rate and clears the counters.
  - Enters ARM next cycle, with trig_out=0 next cycle (a pulse may be truncated).
  - Suppresses burst_done if the retrigger coincides with DONE.
- The strobe has priority over every internal transition in the same cycle.
- Period counter width: $clog2(max(PERIOD_0..3)+1) bits. Elaboration error if any PERIOD_x <= PULSE_WIDTH_CYC or PULSE_WIDTH_CYC=0.
- LED mapping (all inverted, 0 = lit):
  - led[1:0] = ~rate latch.
  - led[2] = ~trig_active.
  - led[3] = ~trig_out.
  - led[5:4] = ~pulse_count[1:0].
  - Registered, one cycle after the source.

Optional Feature:
- TRIG_CONTINUOUS_EN defined: BURST_LEN is ignored and the block never enters DONE. Pulses repeat indefinitely at the latched rate until the next strobe (restart) or reset. burst_done stays 0, and pulse_count wraps from 255 to 0.
- TRIG_CONTINUOUS_EN undefined: finite burst behaviour as above.

Decomposition:
- Shared package trigger_pkg holds:
  - state encoding localparams (IDLE, ARM, HIGH, LOW, DONE)
  - rate code constants RATE_10HZ..RATE_10KHZ (2'b00..2'b11)
  - LED bit index constants
- One natural sub-module, rate_period_lut: combinational map from the 2-bit rate code to the period in cycles, parameterised by PERIOD_0..3. The FSM and counters stay in the top block.

Test Plan:
All scenarios override PERIOD_0..3 = 40/30/20/10, PULSE_WIDTH_CYC=4, ARM_CYC=3, BURST_LEN=3.
- Strobe with rate=2 at cycle 10 -> trig_active=1 at 11; trig_out rises at 14, 34, 54, each high for 4 cycles; burst_done=1 exactly at cycle 74; pulse_count=3 thereafter.
- Reset asserted mid-HIGH at pulse 2 -> trig_out, trig_active, pulse_count go 0 asynchronously and led=6'b111111; no further pulses without a new strobe.
- Strobe rate=3, then strobe rate=0 two cycles after the first rise -> trig_out=0 next cycle; pulse_count=0; new first rise 4 cycles after the second strobe; subsequent rises 40 apart.
- Strobe coincident with the DONE cycle -> burst_done stays 0; new burst starts; trig_active is never deasserted.
- Rate 1 burst, check LEDs: led[1:0]=2'b10, led[2]=0 during the burst, led[3] toggles inverted to trig_out with 1-cycle lag, led[5:4] tracks ~pulse_count.
- With TRIG_CONTINUOUS_EN and rate 3 -> 300 rises 10 cycles apart, no burst_done, pulse_count wraps 255 -> 0.

Source files
------------

// File: rtl/trigger_pkg.sv
// Shared types and constants for the spectrometer trigger sequencer.
package trigger_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    HIGH = 3'd2,
    LOW  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [1:0] RATE_10HZ  = 2'b00;
  localparam logic [1:0] RATE_100HZ = 2'b01;
  localparam logic [1:0] RATE_1KHZ  = 2'b10;
  localparam logic [1:0] RATE_10KHZ = 2'b11;

  localparam int LED_RATE_LSB = 0;
  localparam int LED_ACTIVE   = 2;
  localparam int LED_TRIG     = 3;
  localparam int LED_CNT_LSB  = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rate_period_lut.sv
// Maps the latched 2-bit rate code to a pulse period in sys_clk cycles.
module rate_period_lut
  import trigger_pkg::*;
#(
  parameter int PERIOD_0 = 2700000,
  parameter int PERIOD_1 = 270000,
  parameter int PERIOD_2 = 27000,
  parameter int PERIOD_3 = 2700,
  parameter int CW       = 22
) (
  input  logic [1:0]    rate,
  output logic [CW-1:0] period
);

  always_comb begin
    period = CW'(PERIOD_0);
    case (rate)
      RATE_10HZ:  period = CW'(PERIOD_0);
      RATE_100HZ: period = CW'(PERIOD_1);
      RATE_1KHZ:  period = CW'(PERIOD_2);
      RATE_10KHZ: period = CW'(PERIOD_3);
      default:    period = CW'(PERIOD_0);
    endcase
  end

endmodule

// File: rtl/trigger_sequencer.sv
// Strobe-started burst of fixed-width trigger pulses at a selectable period, plus status LEDs.
// Define TRIG_CONTINUOUS_EN for endless pulsing (no DONE, no burst_done) until restart or reset.
module trigger_sequencer
  import trigger_pkg::*;
#(
  parameter int CLOCK_FREQ      = 27000000,
  parameter int PERIOD_0        = 2700000,
  parameter int PERIOD_1        = 270000,
  parameter int PERIOD_2        = 27000,
  parameter int PERIOD_3        = 2700,
  parameter int PULSE_WIDTH_CYC = 270,
  parameter int ARM_CYC         = 27,
  parameter int BURST_LEN       = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       new_pattern_in,
  input  logic [1:0] pulse_rate,
  output logic       trig_out,
  output logic       trig_active,
  output logic       burst_done,
  output logic [7:0] pulse_count,
  output logic [5:0] led
);

  localparam int MAX_PERIOD = max_int(max_int(PERIOD_0, PERIOD_1), max_int(PERIOD_2, PERIOD_3));
  // Holdoff shares the cycle counter, so the width also covers ARM_CYC.
  localparam int CW = $clog2(max_int(MAX_PERIOD, ARM_CYC) + 1);

  if (PULSE_WIDTH_CYC == 0 || PERIOD_0 <= PULSE_WIDTH_CYC || PERIOD_1 <= PULSE_WIDTH_CYC ||
      PERIOD_2 <= PULSE_WIDTH_CYC || PERIOD_3 <= PULSE_WIDTH_CYC) begin : g_bad_period
    $error("trigger_sequencer: every PERIOD_x must exceed PULSE_WIDTH_CYC, which must be nonzero");
  end
  if (ARM_CYC < 1) begin : g_bad_arm
    $error("trigger_sequencer: ARM_CYC must be at least 1");
  end
  if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_burst
    $error("trigger_sequencer: BURST_LEN must be within 1..255");
  end
  if (CLOCK_FREQ <= 0) begin : g_bad_clk
    $error("trigger_sequencer: CLOCK_FREQ must be positive");
  end

  state_t        state, next_state;
  logic [1:0]    rate_q;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] period;
  logic [CW-1:0] low_last;
  logic          last_pulse;

  rate_period_lut #(
    .PERIOD_0(PERIOD_0),
    .PERIOD_1(PERIOD_1),
    .PERIOD_2(PERIOD_2),
    .PERIOD_3(PERIOD_3),
    .CW      (CW)
  ) u_lut (
    .rate  (rate_q),
    .period(period)
  );

  assign low_last = period - CW'(PULSE_WIDTH_CYC + 1);

`ifdef TRIG_CONTINUOUS_EN
  assign last_pulse = 1'b0;
`else
  assign last_pulse = (pulse_count == 8'(BURST_LEN));
`endif

  always_comb begin
    next_state = state;
    cnt_nxt    = cnt + CW'(1);
    case (state)
      IDLE: cnt_nxt = '0;
      ARM: begin
        if (cnt == CW'(ARM_CYC - 1)) begin
          next_state = HIGH;
          cnt_nxt    = '0;
        end
      end
      HIGH: begin
        if (cnt == CW'(PULSE_WIDTH_CYC - 1)) begin
          next_state = LOW;
          cnt_nxt    = '0;
        end
      end
      LOW: begin
        // The final LOW interval runs in full so DONE lands one period after the last rise.
        if (cnt == low_last) begin
          next_state = last_pulse ? DONE : HIGH;
          cnt_nxt    = '0;
        end
      end
      DONE: begin
        next_state = IDLE;
        cnt_nxt    = '0;
      end
      default: begin
        next_state = IDLE;
        cnt_nxt    = '0;
      end
    endcase
    if (new_pattern_in) begin
      next_state = ARM;
      cnt_nxt    = '0;
    end
  end

  // Outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rate_q      <= RATE_10HZ;
      trig_out    <= 1'b0;
      trig_active <= 1'b0;
      burst_done  <= 1'b0;
      pulse_count <= 8'd0;
    end else begin
      state       <= next_state;
      cnt         <= cnt_nxt;
      trig_out    <= (next_state == HIGH);
      trig_active <= (next_state == ARM) || (next_state == HIGH) || (next_state == LOW);
      burst_done  <= (next_state == DONE);
      if (new_pattern_in) begin
        rate_q      <= pulse_rate;
        pulse_count <= 8'd0;
      end else if (next_state == HIGH && state != HIGH) begin
        pulse_count <= pulse_count + 8'd1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      led <= 6'b111111;
    end else begin
      led[LED_RATE_LSB +: 2] <= ~rate_q;
      led[LED_ACTIVE]        <= ~trig_active;
      led[LED_TRIG]          <= ~trig_out;
      led[LED_CNT_LSB +: 2]  <= ~pulse_count[1:0];
    end
  end

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed bench for trigger_sequencer with short periods (40/30/20/10, width 4, holdoff 3, burst 3).
module tb_trigger_sequencer;

  localparam int ARM = 3;
  localparam int PW  = 4;
  localparam int BL  = 3;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       new_pattern_in = 1'b0;
  logic [1:0] pulse_rate = 2'd0;
  logic       trig_out, trig_active, burst_done;
  logic [7:0] pulse_count;
  logic [5:0] led;

  int n_checks = 0;
  int n_errors = 0;

  trigger_sequencer #(
    .CLOCK_FREQ     (27000000),
    .PERIOD_0       (40),
    .PERIOD_1       (30),
    .PERIOD_2       (20),
    .PERIOD_3       (10),
    .PULSE_WIDTH_CYC(PW),
    .ARM_CYC        (ARM),
    .BURST_LEN      (BL)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .new_pattern_in(new_pattern_in),
    .pulse_rate    (pulse_rate),
    .trig_out      (trig_out),
    .trig_active   (trig_active),
    .burst_done    (burst_done),
    .pulse_count   (pulse_count),
    .led           (led)
  );

  always #5 sys_clk = ~sys_clk;

  // Expected behaviour k cycles after the strobe cycle, for period p.
  function automatic bit exp_ta(input int k, input int p);
`ifdef TRIG_CONTINUOUS_EN
    return (k >= 1);
`else
    return (k >= 1) && (k <= ARM + BL * p);
`endif
  endfunction

  function automatic bit exp_to(input int k, input int p);
    int j;
    if (k < ARM + 1) return 1'b0;
    j = k - ARM - 1;
`ifndef TRIG_CONTINUOUS_EN
    if (j >= BL * p) return 1'b0;
`endif
    return (j % p) < PW;
  endfunction

  function automatic int exp_pc(input int k, input int p);
    int n;
    if (k < ARM + 1) return 0;
    n = (k - ARM - 1) / p + 1;
`ifdef TRIG_CONTINUOUS_EN
    return n % 256;
`else
    return (n > BL) ? BL : n;
`endif
  endfunction

  function automatic bit exp_bd(input int k, input int p);
`ifdef TRIG_CONTINUOUS_EN
    return (k < 0) && (p < 0);
`else
    return k == ARM + 1 + BL * p;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Caller raises the strobe on the negedge of cycle 0; this checks cycles 1..kmax.
  task automatic track(input int p, input logic [1:0] r, input int kmax);
    logic [7:0] pcp;
    logic [5:0] le;
    for (int k = 1; k <= kmax; k++) begin
      @(negedge sys_clk);
      if (k == 1) new_pattern_in = 1'b0;
      chk("trig_out", {31'd0, trig_out}, {31'd0, exp_to(k, p)});
      chk("trig_active", {31'd0, trig_active}, {31'd0, exp_ta(k, p)});
      chk("burst_done", {31'd0, burst_done}, {31'd0, exp_bd(k, p)});
      chk("pulse_count", {24'd0, pulse_count}, 32'(exp_pc(k, p)));
      if (k >= 2) begin
        pcp = 8'(exp_pc(k - 1, p));
        le  = {~pcp[1:0], ~exp_to(k - 1, p), ~exp_ta(k - 1, p), ~r};
        chk("led", {26'd0, led}, {26'd0, le});
      end
    end
  endtask

  task automatic strobe(input logic [1:0] r);
    @(negedge sys_clk);
    new_pattern_in = 1'b1;
    pulse_rate     = r;
  endtask

  initial begin
    repeat (3) @(negedge sys_clk);
    chk("rst_trig_out", {31'd0, trig_out}, 32'd0);
    chk("rst_trig_active", {31'd0, trig_active}, 32'd0);
    chk("rst_burst_done", {31'd0, burst_done}, 32'd0);
    chk("rst_pulse_count", {24'd0, pulse_count}, 32'd0);
    chk("rst_led", {26'd0, led}, 32'h3f);
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    chk("idle_led", {26'd0, led}, 32'h3f);

    // Rate 2 burst: rises at +4, +24, +44; done at +64; count holds afterwards.
    strobe(2'd2);
    track(20, 2'd2, ARM + 1 + BL * 20 + 6);

    // Asynchronous reset in the middle of pulse 2.
    strobe(2'd3);
    track(10, 2'd3, 15);
    chk("pre_rst_trig_out", {31'd0, trig_out}, 32'd1);
    sys_rst_n = 1'b0;
    #1;
    chk("arst_trig_out", {31'd0, trig_out}, 32'd0);
    chk("arst_trig_active", {31'd0, trig_active}, 32'd0);
    chk("arst_pulse_count", {24'd0, pulse_count}, 32'd0);
    chk("arst_led", {26'd0, led}, 32'h3f);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      chk("post_rst_trig_out", {31'd0, trig_out}, 32'd0);
      chk("post_rst_trig_active", {31'd0, trig_active}, 32'd0);
    end

    // Retrigger two cycles after the first rise truncates the pulse and restarts at rate 0.
    strobe(2'd3);
    track(10, 2'd3, 6);
    new_pattern_in = 1'b1;
    pulse_rate     = 2'd0;
    track(40, 2'd0, ARM + 1 + BL * 40 + 3);

    // Strobe in the cycle that would otherwise enter DONE: no burst_done, trig_active stays up.
    strobe(2'd1);
    track(30, 2'd1, ARM + BL * 30);
    new_pattern_in = 1'b1;
    pulse_rate     = 2'd1;
    track(30, 2'd1, ARM + 1 + BL * 30 + 3);

`ifdef TRIG_CONTINUOUS_EN
    // 300 rises at rate 3; pulse_count wraps past 255.
    strobe(2'd3);
    track(10, 2'd3, ARM + 300 * 10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
